// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core (add/sub/and/or/addi/lw/sw/beq) sequenced as
// FETCH/DECODE/EXEC/MEM/WB, with handshaked instruction and data memories.
module multicycle_core #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              halted,
    output logic [XLEN-1:0]   pc_out
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_ILL  = 4'd8
    } op_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

    function automatic op_e decode_op(input logic [31:0] ir);
        op_e op;
        op = OP_ILL;
        case (ir[6:0])
            7'b0110011: begin
                case ({ir[31:25], ir[14:12]})
                    10'b0000000_000: op = OP_ADD;
                    10'b0100000_000: op = OP_SUB;
                    10'b0000000_111: op = OP_AND;
                    10'b0000000_110: op = OP_OR;
                    default:         op = OP_ILL;
                endcase
            end
            7'b0010011: op = (ir[14:12] == 3'b000) ? OP_ADDI : OP_ILL;
            7'b0000011: op = (ir[14:12] == 3'b010) ? OP_LW   : OP_ILL;
            7'b0100011: op = (ir[14:12] == 3'b010) ? OP_SW   : OP_ILL;
            7'b1100011: op = (ir[14:12] == 3'b000) ? OP_BEQ  : OP_ILL;
            default:    op = OP_ILL;
        endcase
        return op;
    endfunction

    // Immediate format follows the opcode; the B-type offset already has bit0 = 0.
    function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ir);
        logic [XLEN-1:0] imm;
        case (ir[6:0])
            7'b0100011: imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            default:    imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
    logic            retire_q, retire_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;

    assign rs1_s     = ir_q[19:15];
    assign rs2_s     = ir_q[24:20];
    assign rd_s      = ir_q[11:7];
    assign rs1_val_s = (rs1_s == 5'd0) ? {XLEN{1'b0}} : rf_q[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? {XLEN{1'b0}} : rf_q[rs2_s];

    // Next-state, datapath and register-file update for the current FSM state.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        retire_d = 1'b0;
        rf_d     = rf_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d    = decode_op(ir_q);
                a_d     = rs1_val_s;
                b_d     = rs2_val_s;
                imm_d   = imm_gen(ir_q);
                state_d = (decode_op(ir_q) == OP_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  begin alu_d = a_q + b_q;   state_d = S_WB;  end
                    OP_SUB:  begin alu_d = a_q - b_q;   state_d = S_WB;  end
                    OP_AND:  begin alu_d = a_q & b_q;   state_d = S_WB;  end
                    OP_OR:   begin alu_d = a_q | b_q;   state_d = S_WB;  end
                    OP_ADDI: begin alu_d = a_q + imm_q; state_d = S_WB;  end
                    OP_LW,
                    OP_SW:   begin alu_d = a_q + imm_q; state_d = S_MEM; end
                    OP_BEQ: begin
                        pc_d     = (a_q == b_q) ? (pc_q + imm_q) : (pc_q + PC_STEP);
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_SW) begin
                        pc_d     = pc_q + PC_STEP;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                if (rd_s != 5'd0) begin
                    rf_d[rd_s] = (op_q == OP_LW) ? mdr_q : alu_q;
                end else begin
                    rf_d[0] = rf_q[0];
                end
                pc_d     = pc_q + PC_STEP;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // State and architectural registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= OP_ILL;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            imm_q    <= {XLEN{1'b0}};
            alu_q    <= {XLEN{1'b0}};
            mdr_q    <= {XLEN{1'b0}};
            retire_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            retire_q <= retire_d;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q[ADDR_W-1:0];
    assign dmem_req   = (state_q == S_MEM);
    assign dmem_we    = (state_q == S_MEM) && (op_q == OP_SW);
    assign dmem_addr  = alu_q[ADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign retire     = retire_q;
    assign halted     = (state_q == S_HALT);
    assign pc_out     = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed programs plus a random
// program, each instruction checked against an instruction-level reference model.
module tb_multicycle_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc_out;

    logic [31:0] imem_mem [256];
    logic [31:0] dmem_mem [256];
    int          iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;
    int          checks = 0, errors = 0;
    logic [31:0] sq_a [$];
    logic [31:0] sq_d [$];

    // instruction-level reference state
    logic [31:0] mreg [32];
    logic [31:0] mdm  [256];
    logic [31:0] mpc;
    int          last_commit;

    always #5 clk = ~clk;

    multicycle_core #(.XLEN(32), .ADDR_W(32), .RESET_PC(32'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .retire(retire), .halted(halted), .pc_out(pc_out)
    );

    assign imem_ready = imem_req && (icnt >= iwait);
    assign imem_rdata = imem_mem[imem_addr[9:2]];
    assign dmem_ready = dmem_req && (dcnt >= dwait);
    assign dmem_rdata = dmem_mem[dmem_addr[9:2]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory wait-state counters and the data-memory write port.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        icnt <= (!reset && imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (!reset && dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (!reset && dmem_req && dmem_ready && dmem_we) begin
            dmem_mem[dmem_addr[9:2]] <= dmem_wdata;
            sq_a.push_back(dmem_addr);
            sq_d.push_back(dmem_wdata);
        end
    end

    logic [31:0] d_addr0, d_wd0, i_addr0;
    logic        d_we0;
    // Requests must hold address/we/wdata steady while waiting for ready.
    always @(negedge clk) begin
        if (!reset && dmem_req) begin
            if (dcnt == 0) begin
                d_addr0 = dmem_addr; d_we0 = dmem_we; d_wd0 = dmem_wdata;
            end else begin
                chk("dmem_addr_stable", dmem_addr, d_addr0);
                chk("dmem_we_stable", dmem_we, d_we0);
                chk("dmem_wdata_stable", dmem_wdata, d_wd0);
            end
        end
        if (!reset && imem_req) begin
            if (icnt == 0) i_addr0 = imem_addr;
            else chk("imem_addr_stable", imem_addr, i_addr0);
        end
    end

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int opc);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 2, rd, 7'h03);
    endfunction

    // Executes the instruction at mpc on the reference state (ISA semantics).
    task automatic model_exec(output bit legal, output bit ismem, output bit isst,
                              output logic [31:0] sa, output logic [31:0] sd, output int base);
        logic [31:0] w, a, b, imm_i, imm_s, imm_b, res;
        bit wr, br;
        w     = imem_mem[mpc[9:2]];
        a     = mreg[w[19:15]];
        b     = mreg[w[24:20]];
        imm_i = {{20{w[31]}}, w[31:20]};
        imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
        imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        legal = 1; ismem = 0; isst = 0; sa = 0; sd = 0; base = 4; res = 0; wr = 0; br = 0;
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) begin res = a + b; wr = 1; end
        else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) begin res = a - b; wr = 1; end
        else if (w[6:0] == 7'h33 && w[14:12] == 3'd7 && w[31:25] == 7'h00) begin res = a & b; wr = 1; end
        else if (w[6:0] == 7'h33 && w[14:12] == 3'd6 && w[31:25] == 7'h00) begin res = a | b; wr = 1; end
        else if (w[6:0] == 7'h13 && w[14:12] == 3'd0) begin res = a + imm_i; wr = 1; end
        else if (w[6:0] == 7'h03 && w[14:12] == 3'd2) begin
            sa = a + imm_i; res = mdm[sa[9:2]]; wr = 1; ismem = 1; base = 5;
        end else if (w[6:0] == 7'h23 && w[14:12] == 3'd2) begin
            sa = a + imm_s; sd = b; mdm[sa[9:2]] = b; isst = 1; ismem = 1;
        end else if (w[6:0] == 7'h63 && w[14:12] == 3'd0) begin
            br = 1; base = 3;
        end else legal = 0;
        if (legal) begin
            if (br) mpc = (a == b) ? mpc + imm_b : mpc + 32'd4;
            else    mpc = mpc + 32'd4;
            if (wr && w[11:7] != 5'd0) mreg[w[11:7]] = res;
        end
    endtask

    // Runs one instruction on the DUT and compares it with the model.
    task automatic exec_one(input int iw, input int dw, output bit done, output logic [31:0] obs_d);
        bit legal, ismem, isst, saw_ret;
        logic [31:0] sa, sd;
        int base, n;
        iwait = iw; dwait = dw; done = 0; obs_d = 32'hDEAD_BEEF; saw_ret = 0;
        model_exec(legal, ismem, isst, sa, sd, base);
        if (!legal) begin
            n = 0;
            while (!halted && n < 2 + iw) begin
                @(negedge clk); n++;
                if (retire) saw_ret = 1;
            end
            chk("halt_latency", halted, 1);
            chk("halt_no_retire", saw_ret, 0);
            repeat (10) begin
                @(negedge clk);
                chk("halt_hold", {imem_req, dmem_req, retire, halted}, 4'b0001);
            end
            done = 1;
            return;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!retire && n < 200);
        chk("retire_seen", retire, 1);
        chk("cycles_per_instr", cyc - last_commit, base + iw + (ismem ? dw : 0));
        last_commit = cyc;
        chk("pc_out", pc_out, mpc);
        chk("imem_addr", imem_addr, mpc);
        chk("halted_low", halted, 0);
        if (isst) begin
            chk("store_seen", sq_a.size() != 0, 1);
            if (sq_a.size() != 0) begin
                obs_d = sq_d.pop_front();
                chk("store_addr", sq_a.pop_front(), sa);
                chk("store_data", obs_d, sd);
            end
        end else begin
            chk("no_store", sq_a.size(), 0);
        end
    endtask

    task automatic do_reset(input logic [31:0] prog [$]);
        reset = 1'b1; iwait = 0; dwait = 0;
        for (int i = 0; i < 256; i++) imem_mem[i] = (i < prog.size()) ? prog[i] : 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_commit = cyc;
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    endtask

    initial begin
        logic [31:0] prog [$];
        logic [31:0] d, w0;
        logic [31:0] alu_exp [4];
        bit done;
        int r;

        for (int i = 0; i < 256; i++) begin
            dmem_mem[i] = $urandom;
            mdm[i] = dmem_mem[i];
        end
        w0 = mdm[0];
        alu_exp[0] = 32'd2; alu_exp[1] = 32'd8; alu_exp[2] = 32'd5; alu_exp[3] = 32'hFFFF_FFFD;

        // Phase 1: reset state, register readback, ALU, x0, illegal.
        prog = {};
        for (int i = 1; i < 32; i++) prog.push_back(enc_s(32'h180 + 4 * (i - 1), i, 0));
        prog.push_back(addi(1, 0, 5));
        prog.push_back(addi(2, 0, -3));
        prog.push_back(enc_r(7'h00, 2, 1, 0, 3));
        prog.push_back(enc_r(7'h20, 2, 1, 0, 4));
        prog.push_back(enc_r(7'h00, 2, 1, 7, 5));
        prog.push_back(enc_r(7'h00, 2, 1, 6, 6));
        for (int i = 0; i < 4; i++) prog.push_back(enc_s(32'h100 + 4 * i, 3 + i, 0));
        prog.push_back(addi(0, 0, 7));
        prog.push_back(enc_s(32'h110, 0, 0));
        do_reset(prog);
        chk("rst_outputs", {imem_req, dmem_req, dmem_we, retire, halted}, 5'b10000);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        for (int i = 1; i < 32; i++) begin
            exec_one(0, 0, done, d);
            chk($sformatf("reset_reg_x%0d", i), d, 32'd0);
        end
        for (int i = 0; i < 6; i++) exec_one(0, 0, done, d);
        for (int i = 0; i < 4; i++) begin
            exec_one(0, 0, done, d);
            chk($sformatf("alu_store_%0d", i), d, alu_exp[i]);
        end
        exec_one(0, 0, done, d);
        exec_one(0, 0, done, d);
        chk("x0_store", d, 32'd0);
        exec_one(0, 0, done, d);
        chk("illegal_halts", done, 1);

        // Phase 2: wait states on lw, branches taken/not taken.
        prog = {};
        prog.push_back(addi(1, 0, 5));            // 0
        prog.push_back(addi(2, 0, 9));            // 4
        prog.push_back(lw(7, 0, 0));              // 8
        prog.push_back(enc_s(32'h120, 7, 0));     // 12
        prog.push_back(enc_b(16, 2, 1));          // 16: not taken
        prog.push_back(enc_b(12, 0, 0));          // 20: -> 32
        prog.push_back(enc_s(32'h124, 1, 0));     // 24
        prog.push_back(32'hFFFF_FFFF);            // 28
        prog.push_back(enc_b(-8, 1, 1));          // 32: -> 24
        do_reset(prog);
        exec_one(0, 0, done, d);
        exec_one(0, 0, done, d);
        exec_one(2, 3, done, d);
        exec_one(0, 0, done, d);
        chk("lw_data", d, w0);
        exec_one(0, 0, done, d);
        chk("beq_not_taken_pc", pc_out, 32'd20);
        exec_one(0, 0, done, d);
        chk("beq_fwd_pc", pc_out, 32'd32);
        exec_one(0, 0, done, d);
        chk("beq_back_pc", imem_addr, 32'd24);
        exec_one(0, 0, done, d);
        chk("store_after_branch", d, 32'd5);
        exec_one(0, 0, done, d);

        // Phase 3: reset while a store is waiting in MEM.
        prog = {};
        prog.push_back(addi(1, 0, 3));
        prog.push_back(enc_s(32'h130, 1, 0));
        do_reset(prog);
        exec_one(0, 0, done, d);
        dwait = 20;
        r = 0;
        while (!dmem_req && r < 20) begin @(negedge clk); r++; end
        chk("mem_reached", dmem_req, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midmem_reset_out", {dmem_req, dmem_we, imem_req, retire}, 4'b0010);
        chk("midmem_reset_pc", pc_out, 32'd0);
        reset = 1'b0;
        dwait = 0;
        last_commit = cyc;
        mpc = 32'd0;
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        chk("midmem_no_store", sq_a.size(), 0);
        exec_one(0, 0, done, d);
        exec_one(0, 0, done, d);
        chk("restart_store", d, 32'd3);
        exec_one(0, 0, done, d);

        // Phase 4: random program with random wait states.
        prog = {};
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 7);
            if (r == 7 && k > 56) r = 4;
            case (r)
                0: prog.push_back(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 7)));
                1: prog.push_back(enc_r(7'h20, $urandom_range(0, 7), $urandom_range(0, 7), 0, $urandom_range(0, 7)));
                2: prog.push_back(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 7, $urandom_range(0, 7)));
                3: prog.push_back(enc_r(7'h00, $urandom_range(0, 7), $urandom_range(0, 7), 6, $urandom_range(0, 7)));
                4: prog.push_back(addi($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4095)));
                5: prog.push_back(lw($urandom_range(0, 7), 0, 32'h100 + 4 * $urandom_range(0, 63)));
                6: prog.push_back(enc_s(32'h100 + 4 * $urandom_range(0, 63), $urandom_range(0, 7), 0));
                default: prog.push_back(enc_b(4 * $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
            endcase
        end
        do_reset(prog);
        done = 0;
        r = 0;
        while (!done && r < 80) begin
            exec_one($urandom_range(0, 2), $urandom_range(0, 2), done, d);
            r++;
        end
        chk("random_reached_halt", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
